// File: rtl/elliptic_curve_structs.sv
`default_nettype none
// ============================================================================
// Package     : elliptic_curve_structs
// Description : Shared curve point type, sequencer state encoding and
//               default sub-operation timeout for point multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
package elliptic_curve_structs;

  localparam int unsigned CURVE_WIDTH = 256;
  localparam int unsigned PM_TIMEOUT  = 65535;

  typedef struct packed {
    logic [CURVE_WIDTH-1:0] x;
    logic [CURVE_WIDTH-1:0] y;
  } curve_point_t;

  typedef enum logic [2:0] {
    PM_IDLE     = 3'd0,
    PM_SCAN     = 3'd1,
    PM_DBL_REQ  = 3'd2,
    PM_DBL_WAIT = 3'd3,
    PM_ADD_REQ  = 3'd4,
    PM_ADD_WAIT = 3'd5,
    PM_DONE     = 3'd6
  } pm_state_t;

endpackage
`default_nettype wire

// File: rtl/ec_subop_launcher.sv
`default_nettype none
// ============================================================================
// Module      : ec_subop_launcher
// Description : Restart/handshake helper for one curve arithmetic unit.
//               Holds the unit in restart outside its WAIT state, ignores a
//               Done level on the first WAIT cycle (left over from the
//               previous operation) and flags a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ec_subop_launcher #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic Reset,
  input  logic active,
  input  logic unit_done,
  output logic restart,
  output logic accept,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo;

  // Count completed WAIT cycles; cleared whenever the unit is not being waited on.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      tmo <= '0;
    end else if (!active) begin
      tmo <= '0;
    end else begin
      tmo <= tmo + CNT_W'(1);
    end
  end

  assign restart = !active;
  // tmo is zero only on the first WAIT cycle, where Done may still be stale.
  assign accept  = active && (tmo != '0) && unit_done;
  assign expired = active && !accept && (tmo == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/point_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : point_mult_ctrl
// Description : Left-to-right double-and-add sequencer for R = k*P. Drives
//               point_double / point_add operands and restarts, and offers a
//               single start/done transaction per scalar multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module point_mult_ctrl
  import elliptic_curve_structs::*;
#(
  parameter int unsigned WIDTH   = CURVE_WIDTH,
  parameter int unsigned TIMEOUT = PM_TIMEOUT
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] k,
  input  curve_point_t     P,
  output logic             busy,
  output logic             done,
  output logic             err,
  output curve_point_t     R,
  output logic             R_inf,
  output logic             dbl_rst,
  output curve_point_t     dbl_in,
  input  logic             dbl_done,
  input  curve_point_t     dbl_R,
  output logic             add_rst,
  output curve_point_t     add_P,
  output curve_point_t     add_Q,
  input  logic             add_done,
  input  curve_point_t     add_R
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  pm_state_t        state, state_d;
  logic [WIDTH-1:0] k_q, k_d;
  curve_point_t     p_q, p_d;
  curve_point_t     acc, acc_d;
  curve_point_t     res, res_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             err_q, err_d;
  logic             rinf_q, rinf_d;
  logic             dbl_accept, dbl_expired;
  logic             add_accept, add_expired;

  ec_subop_launcher #(.TIMEOUT(TIMEOUT)) u_dbl_launch (
    .clk       (clk),
    .Reset     (Reset),
    .active    (state == PM_DBL_WAIT),
    .unit_done (dbl_done),
    .restart   (dbl_rst),
    .accept    (dbl_accept),
    .expired   (dbl_expired)
  );

  ec_subop_launcher #(.TIMEOUT(TIMEOUT)) u_add_launch (
    .clk       (clk),
    .Reset     (Reset),
    .active    (state == PM_ADD_WAIT),
    .unit_done (add_done),
    .restart   (add_rst),
    .accept    (add_accept),
    .expired   (add_expired)
  );

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state  <= PM_IDLE;
      k_q    <= '0;
      p_q    <= '0;
      acc    <= '0;
      res    <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      rinf_q <= 1'b0;
    end else begin
      state  <= state_d;
      k_q    <= k_d;
      p_q    <= p_d;
      acc    <= acc_d;
      res    <= res_d;
      idx    <= idx_d;
      err_q  <= err_d;
      rinf_q <= rinf_d;
    end
  end

  // Next-state logic: bit scan, double/add requests, completion and errors.
  always_comb begin
    state_d = state;
    k_d     = k_q;
    p_d     = p_q;
    acc_d   = acc;
    res_d   = res;
    idx_d   = idx;
    err_d   = err_q;
    rinf_d  = rinf_q;
    case (state)
      PM_IDLE: begin
        if (start) begin
          k_d     = k;
          p_d     = P;
          idx_d   = IDX_W'(WIDTH - 1);
          err_d   = 1'b0;
          rinf_d  = 1'b0;
          state_d = PM_SCAN;
        end
      end
      PM_SCAN: begin
        if (k_q[idx]) begin
          acc_d = p_q;
          if (idx == '0) begin
            state_d = PM_DONE;
          end else begin
            idx_d   = idx - IDX_W'(1);
            state_d = PM_DBL_REQ;
          end
        end else if (idx == '0) begin
          rinf_d  = 1'b1;
          state_d = PM_DONE;
        end else begin
          idx_d = idx - IDX_W'(1);
        end
      end
      PM_DBL_REQ: begin
        if (acc.y == '0) begin
          err_d   = 1'b1;
          state_d = PM_DONE;
        end else begin
          state_d = PM_DBL_WAIT;
        end
      end
      PM_DBL_WAIT: begin
        if (dbl_accept) begin
          acc_d = dbl_R;
          if (k_q[idx]) begin
            state_d = PM_ADD_REQ;
          end else if (idx == '0) begin
            state_d = PM_DONE;
          end else begin
            idx_d   = idx - IDX_W'(1);
            state_d = PM_DBL_REQ;
          end
        end else if (dbl_expired) begin
          err_d   = 1'b1;
          state_d = PM_DONE;
        end
      end
      PM_ADD_REQ: begin
        if (acc.x == p_q.x) begin
          err_d   = 1'b1;
          state_d = PM_DONE;
        end else begin
          state_d = PM_ADD_WAIT;
        end
      end
      PM_ADD_WAIT: begin
        if (add_accept) begin
          acc_d = add_R;
          if (idx == '0) begin
            state_d = PM_DONE;
          end else begin
            idx_d   = idx - IDX_W'(1);
            state_d = PM_DBL_REQ;
          end
        end else if (add_expired) begin
          err_d   = 1'b1;
          state_d = PM_DONE;
        end
      end
      PM_DONE: state_d = PM_IDLE;
      default: state_d = PM_IDLE;
    endcase
    // Result is captured on entry to DONE and held until it is next overwritten.
    if (state_d == PM_DONE && state != PM_DONE) begin
      res_d = (err_d || rinf_d) ? '0 : acc_d;
    end
  end

  assign busy   = (state != PM_IDLE);
  assign done   = (state == PM_DONE);
  assign err    = err_q;
  assign R_inf  = rinf_q;
  assign R      = res;
  assign dbl_in = acc;
  assign add_P  = acc;
  assign add_Q  = p_q;

endmodule
`default_nettype wire
